// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared op encoding and constants for the sequential ALU
package cpu_types_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_MUL  = 4'd12,
    OP_MULU = 4'd13,
    OP_DIV  = 4'd14,
    OP_DIVU = 4'd15
  } seqaluop_t;

  // Iteration steps of the multiply/divide datapath at the default 32-bit width.
  localparam int SEQ_ALU_MD_CYCLES = 32;

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - port bundle for seq_alu with block and testbench views
interface seq_alu_if #(
  parameter int WIDTH = 32
) (
  input logic CLK
);
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             resp_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             negative;
  logic             overflow;
  logic             zero;
  logic             div_zero;

  modport dut (
    input  CLK, RST, req_valid, aluop, port_a, port_b,
    output req_ready, resp_valid, out, out_hi, negative, overflow, zero, div_zero
  );

  modport tb (
    input  CLK, req_ready, resp_valid, out, out_hi, negative, overflow, zero, div_zero,
    output RST, req_valid, aluop, port_a, port_b
  );
endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// rtl/seq_alu_muldiv_iter.sv - iterative shift-add multiply / restoring divide on magnitudes
// Divider datapath only present when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv_iter import cpu_types_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  seqaluop_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             res_ovf,
  output logic             res_dz
);
  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, mb;
  logic             signed_q, neg_q;
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] ma_c, mb_c;
  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_s;

`ifdef SEQ_ALU_DIV_EN
  logic             is_div, div_q, neg_r, dz_q, minovf_q;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   dshift, dsub;
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_signed = (op == OP_MUL);
`endif

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign ma_c  = a_neg ? -a : a;
  assign mb_c  = b_neg ? -b : b;
  assign last  = busy && (count == CW'(WIDTH-1));

  // hi holds the partial product / remainder, lo the multiplier / quotient bits.
  always_comb begin
    madd = {1'b0, hi} + (lo[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
    hi_n = madd[WIDTH:1];
    lo_n = {madd[0], lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    dshift = {hi, lo[WIDTH-1]};
    dsub   = dshift - {1'b0, mb};
    if (div_q) begin
      if (!dsub[WIDTH]) begin
        hi_n = dsub[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = dshift[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    prod    = {hi_n, lo_n};
    prod_s  = neg_q ? -prod : prod;
    res_lo  = prod_s[WIDTH-1:0];
    res_hi  = prod_s[2*WIDTH-1:WIDTH];
    res_ovf = signed_q ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0);
    res_dz  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    if (div_q) begin
      res_lo  = neg_q ? -lo_n : lo_n;
      res_hi  = neg_r ? -hi_n : hi_n;
      res_ovf = minovf_q;
      res_dz  = dz_q;
      if (dz_q) begin
        res_lo = '1;
        res_hi = a_raw;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= '0;
      hi       <= '0;
      lo       <= ma_c;
      mb       <= mb_c;
      signed_q <= is_signed;
      neg_q    <= a_neg ^ b_neg;
`ifdef SEQ_ALU_DIV_EN
      div_q    <= is_div;
      neg_r    <= a_neg;
      dz_q     <= is_div && (b == '0);
      minovf_q <= is_signed && is_div && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      a_raw    <= a;
`endif
    end else if (busy) begin
      hi    <= hi_n;
      lo    <= lo_n;
      count <= count + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle execute-stage ALU with valid/ready request and registered results
// SEQ_ALU_DIV_EN builds the iterative divider; otherwise DIV/DIVU complete at once flagged overflow.
module seq_alu import cpu_types_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             resp_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic             ready_q;
  seqaluop_t        op;
  logic             accept, is_mul, is_md;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_out;
  logic             sc_ovf;
  logic             md_last, md_ovf, md_dz;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op        = seqaluop_t'(aluop);
  assign req_ready = ready_q & ~RST;
  assign accept    = req_valid & req_ready;
  assign sh        = port_b[SHW-1:0];
  assign is_mul    = (op == OP_MUL) || (op == OP_MULU);
`ifdef SEQ_ALU_DIV_EN
  assign is_md     = is_mul || (op == OP_DIV) || (op == OP_DIVU);
`else
  assign is_md     = is_mul;
`endif

  seq_alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (CLK),
    .rst     (RST),
    .start   (accept && is_md),
    .op      (op),
    .a       (port_a),
    .b       (port_b),
    .last    (md_last),
    .res_lo  (md_lo),
    .res_hi  (md_hi),
    .res_ovf (md_ovf),
    .res_dz  (md_dz)
  );

  always_comb begin
    sc_out = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        sc_out = port_a + port_b;
        sc_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sc_out[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out = port_a - port_b;
        sc_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (sc_out[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_AND:  sc_out = port_a & port_b;
      OP_OR:   sc_out = port_a | port_b;
      OP_XOR:  sc_out = port_a ^ port_b;
      OP_NOR:  sc_out = ~(port_a | port_b);
      OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
      OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, port_a < port_b};
      OP_SLL:  sc_out = port_a << sh;
      OP_SRL:  sc_out = port_a >> sh;
      OP_SRA:  sc_out = $unsigned($signed(port_a) >>> sh);
      OP_LUI:  sc_out = port_b << (WIDTH/2);
`ifndef SEQ_ALU_DIV_EN
      // No divider: result stays zero and overflow marks the op as unimplemented.
      OP_DIV, OP_DIVU: sc_ovf = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      ready_q    <= 1'b1;
      resp_valid <= 1'b0;
      out        <= '0;
      out_hi     <= '0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && is_md) begin
            state   <= is_mul ? S_MUL : S_DIV;
            ready_q <= 1'b0;
          end else if (accept) begin
            resp_valid <= 1'b1;
            out        <= sc_out;
            out_hi     <= '0;
            negative   <= sc_out[WIDTH-1];
            overflow   <= sc_ovf;
            zero       <= (sc_out == '0);
            div_zero   <= 1'b0;
          end
        end
        default: begin
          if (md_last) begin
            state      <= S_IDLE;
            ready_q    <= 1'b1;
            resp_valid <= 1'b1;
            out        <= md_lo;
            out_hi     <= md_hi;
            negative   <= md_lo[WIDTH-1];
            overflow   <= md_ovf;
            zero       <= (md_lo == '0);
            div_zero   <= md_dz;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (honours SEQ_ALU_DIV_EN)
module tb_seq_alu;
  import cpu_types_pkg::*;

  typedef struct {
    logic [31:0] o;
    logic [31:0] h;
    logic        n, v, z, dz;
    int          lat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus (.CLK(clk));

  seq_alu #(.WIDTH(32)) dut (
    .CLK        (clk),
    .RST        (bus.RST),
    .req_valid  (bus.req_valid),
    .req_ready  (bus.req_ready),
    .aluop      (bus.aluop),
    .port_a     (bus.port_a),
    .port_b     (bus.port_b),
    .resp_valid (bus.resp_valid),
    .out        (bus.out),
    .out_hi     (bus.out_hi),
    .negative   (bus.negative),
    .overflow   (bus.overflow),
    .zero       (bus.zero),
    .div_zero   (bus.div_zero)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e = '{o: 32'h0, h: 32'h0, n: 1'b0, v: 1'b0, z: 1'b0, dz: 1'b0, lat: 1, cyc: 0};
    case (seqaluop_t'(op))
      OP_ADD: begin e.o = a + b; e.v = (a[31] == b[31]) && (e.o[31] != a[31]); end
      OP_SUB: begin e.o = a - b; e.v = (a[31] != b[31]) && (e.o[31] != a[31]); end
      OP_AND:  e.o = a & b;
      OP_OR:   e.o = a | b;
      OP_XOR:  e.o = a ^ b;
      OP_NOR:  e.o = ~(a | b);
      OP_SLT:  e.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.o = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  e.o = a << b[4:0];
      OP_SRL:  e.o = a >> b[4:0];
      OP_SRA:  e.o = $signed(a) >>> b[4:0];
      OP_LUI:  e.o = b << 16;
      OP_MUL: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.o = p[31:0]; e.h = p[63:32];
        e.v = (e.h != {32{e.o[31]}});
        e.lat = SEQ_ALU_MD_CYCLES + 1;
      end
      OP_MULU: begin
        p = {32'h0, a} * {32'h0, b};
        e.o = p[31:0]; e.h = p[63:32];
        e.v = (e.h != 32'h0);
        e.lat = SEQ_ALU_MD_CYCLES + 1;
      end
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        e.lat = SEQ_ALU_MD_CYCLES + 1;
        if (b == 32'h0) begin
          e.o = 32'hFFFF_FFFF; e.h = a; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.o = 32'h8000_0000; e.h = 32'h0; e.v = 1'b1;
        end else begin
          e.o = $signed(a) / $signed(b);
          e.h = $signed(a) % $signed(b);
        end
      end
      OP_DIVU: begin
        e.lat = SEQ_ALU_MD_CYCLES + 1;
        if (b == 32'h0) begin
          e.o = 32'hFFFF_FFFF; e.h = a; e.dz = 1'b1;
        end else begin
          e.o = a / b; e.h = a % b;
        end
      end
`else
      OP_DIV, OP_DIVU: e.v = 1'b1;
`endif
      default: ;
    endcase
    e.n = e.o[31];
    e.z = (e.o == 32'h0);
    return e;
  endfunction

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    exp_t e;
    int   g = 0;
    bus.req_valid = 1'b1;
    bus.aluop     = op;
    bus.port_a    = a;
    bus.port_b    = b;
    while (bus.req_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    e     = model(op, a, b);
    acc   = cyc;
    e.cyc = cyc + e.lat;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        check("out", {32'h0, bus.out}, {32'h0, e.o});
        check("out_hi", {32'h0, bus.out_hi}, {32'h0, e.h});
        check("flags_nvz", {61'h0, bus.negative, bus.overflow, bus.zero}, {61'h0, e.n, e.v, e.z});
        check("div_zero", {63'h0, bus.div_zero}, {63'h0, e.dz});
      end
    end
  end

  logic [31:0] edge_vals [8];

  initial begin
    int acc1, acc2, g;
    logic [3:0] abort_op;
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                  32'h2, 32'hFFFF_FFF9, 32'h0000_0009};

    bus.RST = 1'b1;
    bus.req_valid = 1'b0;
    bus.aluop = 4'h0;
    bus.port_a = 32'h0;
    bus.port_b = 32'h0;
    @(negedge clk);
    check("rst_ready_low", {63'h0, bus.req_ready}, 64'd0);
    @(negedge clk);
    bus.RST = 1'b0;
    #1;
    check("rst_ready_high", {63'h0, bus.req_ready}, 64'd1);
    check("rst_out", {bus.out_hi, bus.out}, 64'd0);
    check("rst_flags", {59'h0, bus.resp_valid, bus.negative, bus.overflow, bus.zero, bus.div_zero}, 64'd0);
    @(negedge clk);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, acc1);
    issue(OP_SUB, 32'd5, 32'd5, acc1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, acc2);
    check("b2b_accept", 64'(acc2 - acc1), 64'd1);
    issue(OP_LUI, 32'h0, 32'h0000_ABCD, acc1);
    issue(OP_SRA, 32'h8000_0000, 32'hFFFF_FF24, acc1);

    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, acc1);
    check("mul_busy_ready", {63'h0, bus.req_ready}, 64'd0);
    issue(OP_MULU, 32'hFFFF_FFFF, 32'd2, acc2);
    check("held_accept", 64'(acc2 - acc1), 64'(SEQ_ALU_MD_CYCLES + 1));

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, acc1);
    issue(OP_DIVU, 32'd9, 32'd0, acc1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, acc1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, acc1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 7)] : $urandom();
      b = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 7)] : $urandom();
      issue(4'($urandom_range(0, 15)), a, b, acc1);
    end

`ifdef SEQ_ALU_DIV_EN
    abort_op = OP_DIVU;
`else
    abort_op = OP_MULU;
`endif
    g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge clk); g++; end
    issue(abort_op, 32'd100, 32'd7, acc1);
    void'(sb.pop_back());
    while (cyc < acc1 + 10) @(negedge clk);
    bus.RST = 1'b1;
    #1;
    check("abort_ready_low", {63'h0, bus.req_ready}, 64'd0);
    @(negedge clk);
    bus.RST = 1'b0;
    #1;
    check("abort_ready_high", {63'h0, bus.req_ready}, 64'd1);
    @(negedge clk);
    repeat (40) @(negedge clk);
    issue(OP_ADD, 32'd3, 32'd4, acc1);

    g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge clk); g++; end
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
